fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage of the 5-stage RISC-V pipeline, directly upstream of the hazard/flush controller's consumers.
- Owns the PC register, drives the synchronous instruction BRAM, and holds the IF/ID pipeline register.
- Takes stall, flush and pc_sel from the pipeline controller, plus branch/jump targets from EX.
- Halts fetch on an illegal redirect target: misaligned, or outside the BRAM region 0x0xxxxxxx.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IMEM_AW, 12, instruction BRAM word-address width (4096 words).
- NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset. Single clock domain: clk.
- stall  in  1  load-use stall. Holds PC and IF/ID.
- flush  in  1  squash IF/ID. Always accompanied by a redirect pc_sel.
- pc_sel  in  2  00=PC+4, 01=branch target, 10=jump target, 11=treated as 00.
- branch_target  in  32  branch destination.
- jump_target  in  32  JAL/JALR destination.
- imem_addr  out  IMEM_AW  BRAM word address, equal to pc_next[IMEM_AW+1:2].
- imem_en  out  1  BRAM read enable.
- imem_rdata  in  32  BRAM read data. Valid 1 cycle after the address is presented with imem_en.
- IF_ID_pc  out  32  PC of the instruction in IF/ID.
- IF_ID_pc_plus4  out  32  IF_ID_pc+4, used for link.
- IF_ID_instr  out  32  instruction in IF/ID.
- IF_ID_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  fetch stopped on an illegal target.
- halt_cause  out  2  00 none, 01 misaligned, 10 outside BRAM region.
- fetch_count  out  32  count of valid instructions loaded into IF/ID.

Behaviour:
- Reset values (async, take effect immediately):
  - pc_q=RESET_PC, state=BOOT.
  - IF_ID_pc=0, IF_ID_pc_plus4=4, IF_ID_instr=NOP_INSTR, IF_ID_valid=0.
  - halted=0, halt_cause=00, fetch_count=0.
- States:
  - BOOT: one cycle. pc_next=RESET_PC, imem_en=1, IF/ID keeps its bubble, inputs ignored. Next state is RUN; pc_q stays RESET_PC.
  - RUN: normal fetch.
  - HALT: terminal until reset.
- pc_next in RUN, highest priority first:
  - pc_sel=10 → jump_target
  - pc_sel=01 → branch_target
  - stall → pc_q
  - otherwise pc_q+4, modulo 2^32 (wrap from 0xFFFFFFFC to 0).
- imem_addr is combinational from pc_next, so the BRAM output at any cycle corresponds to pc_q. imem_en=1 in BOOT and RUN, 0 in HALT.
- IF/ID update on the RUN edge, highest priority first:
  - flush → instr=NOP_INSTR, valid=0, pc=0.
  - stall → hold all IF/ID fields.
  - otherwise → pc=pc_q, instr=imem_rdata, valid=1, pc_plus4=pc_q+4.
- flush together with stall: flush wins, and the PC takes the redirect target.
- fetch_count increments by 1 on each edge that loads valid=1. It wraps at 2^32.
- Redirect check applies when pc_sel is 01 or 10 in RUN:
  - target[1:0]≠0 → cause 01.
  - otherwise target[31:28]≠0 → cause 10.
  - On either cause: state→HALT, halted=1, halt_cause latched, IF/ID loaded with bubble, pc_q frozen at its current value.
- In HALT: imem_en=0, all inputs ignored, IF/ID stays a bubble, fetch_count frozen.
- Reset asserted mid-operation returns all registers to their reset values asynchronously. Operation restarts through BOOT.
- Latency: the instruction at address A is visible in IF/ID two edges after A becomes pc_next. Steady-state throughput is 1 instruction per cycle.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR constant.
  - pc_sel encodings (PC_SEQ, PC_BRANCH, PC_JUMP).
  - state encoding (ST_BOOT, ST_RUN, ST_HALT).
  - halt_cause codes.
  - BRAM region nibble 4'h0.
- Sub-module fetch_pc_mux (combinational): pc_next selection plus the target legality check. The rest stays flat in fetch_unit.

Test Plan:
- Reset release, no stall/flush, BRAM holding word i = 0x1000+i → IF_ID_valid rises on the 2nd edge after reset release. IF_ID_pc sequence is 0,4,8,… with instr 0x1000,0x1001,…; fetch_count=3 after 3 valid loads.
- stall high for 2 cycles while IF_ID_pc=8 → IF_ID holds pc 8 for both cycles, then continues at 0xC. No instruction is lost or duplicated.
- pc_sel=01, flush=1, branch_target=0x40 while pc_q=0x10 → next IF/ID is a bubble (valid=0, instr=0x00000013). The following IF/ID is pc 0x40; fetch_count does not count the bubble.
- flush=1, stall=1, pc_sel=10, jump_target=0x80 in the same cycle → bubble, then pc 0x80 (flush wins).
- jump_target=0x42 → halted=1, halt_cause=01, imem_en=0. Separately, branch_target=0x2000_0000 → halt_cause=10. Asserting rst then restarts at RESET_PC.
- Assert rst asynchronously mid-stream → outputs return to reset values without waiting for a clk edge. Fetch resumes at 0 after BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage.
// Holds pc_sel encodings, FSM states, halt causes and the IF/ID bundle.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [3:0] IMEM_REGION = 4'h0;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE     = 2'b00,
        HC_MISALIGN = 2'b01,
        HC_REGION   = 2'b10
    } halt_cause_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // Misalignment outranks the region check.
    function automatic halt_cause_t check_target(
        input logic [31:0] t
    );
        if (t[1:0] != 2'b00) begin
            return HC_MISALIGN;
        end
        if (t[31:28] != IMEM_REGION) begin
            return HC_REGION;
        end
        return HC_NONE;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of controller, EX-target, BRAM and IF/ID signals for fetch_unit.
// slave: fetch_unit side; master: pipeline/BRAM environment side.
interface fetch_if #(
    parameter int IMEM_AW = 12
);
    logic               stall;
    logic               flush;
    logic [1:0]         pc_sel;
    logic [31:0]        branch_target;
    logic [31:0]        jump_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_en;
    logic [31:0]        imem_rdata;
    logic [31:0]        IF_ID_pc;
    logic [31:0]        IF_ID_pc_plus4;
    logic [31:0]        IF_ID_instr;
    logic               IF_ID_valid;
    logic               halted;
    logic [1:0]         halt_cause;
    logic [31:0]        fetch_count;

    modport slave (
        input  stall, flush, pc_sel,
        input  branch_target, jump_target,
        input  imem_rdata,
        output imem_addr, imem_en,
        output IF_ID_pc, IF_ID_pc_plus4,
        output IF_ID_instr, IF_ID_valid,
        output halted, halt_cause, fetch_count
    );

    modport master (
        output stall, flush, pc_sel,
        output branch_target, jump_target,
        output imem_rdata,
        input  imem_addr, imem_en,
        input  IF_ID_pc, IF_ID_pc_plus4,
        input  IF_ID_instr, IF_ID_valid,
        input  halted, halt_cause, fetch_count
    );

endinterface

// File: rtl/fetch_pc_mux.sv
// Next-PC selection for the RUN state plus redirect-target legality check.
// Ports: pc_q_i, pc_sel_i, stall_i, targets in; pc_next_o, illegal_o, cause_o out.
module fetch_pc_mux
    import fetch_pkg::*;
(
    input  logic [31:0] pc_q_i,
    input  logic [1:0]  pc_sel_i,
    input  logic        stall_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] pc_next_o,
    output logic        illegal_o,
    output halt_cause_t cause_o
);

    always_comb begin
        pc_next_o = pc_q_i + 32'd4;
        cause_o   = HC_NONE;
        priority case (1'b1)
            (pc_sel_i == PC_JUMP): begin
                pc_next_o = jump_target_i;
                cause_o   = check_target(jump_target_i);
            end
            (pc_sel_i == PC_BRANCH): begin
                pc_next_o = branch_target_i;
                cause_o   = check_target(branch_target_i);
            end
            stall_i: begin
                pc_next_o = pc_q_i;
            end
            default: begin
            end
        endcase
        illegal_o = (cause_o != HC_NONE);
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, synchronous BRAM addressing and the IF/ID register.
// Ports: clk, rst (async active-high), bus (fetch_if.slave) with all data.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 12,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input logic    clk,
    input logic    rst,
    fetch_if.slave bus
);
    import fetch_pkg::*;

    localparam if_id_t IFID_BUBBLE = '{
        pc:       32'd0,
        pc_plus4: 32'd4,
        instr:    NOP_INSTR,
        valid:    1'b0
    };

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      ifid_q, ifid_d;
    logic        halted_q, halted_d;
    halt_cause_t cause_q, cause_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] pc_next;
    logic        imem_en;
    logic [31:0] mux_pc;
    logic        mux_illegal;
    halt_cause_t mux_cause;

    fetch_pc_mux u_pc_mux (
        .pc_q_i          (pc_q),
        .pc_sel_i        (bus.pc_sel),
        .stall_i         (bus.stall),
        .branch_target_i (bus.branch_target),
        .jump_target_i   (bus.jump_target),
        .pc_next_o       (mux_pc),
        .illegal_o       (mux_illegal),
        .cause_o         (mux_cause)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ifid_d   = ifid_q;
        halted_d = halted_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        pc_next  = pc_q;
        imem_en  = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                // pc_q already holds RESET_PC; just prime the BRAM.
                pc_next = RESET_PC;
                imem_en = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                pc_next = mux_pc;
                imem_en = 1'b1;
                if (mux_illegal) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    cause_d  = mux_cause;
                    ifid_d   = IFID_BUBBLE;
                end else begin
                    pc_d = mux_pc;
                    priority case (1'b1)
                        bus.flush: begin
                            ifid_d = IFID_BUBBLE;
                        end
                        bus.stall: begin
                        end
                        default: begin
                            ifid_d.pc       = pc_q;
                            ifid_d.pc_plus4 = pc_q + 32'd4;
                            ifid_d.instr    = bus.imem_rdata;
                            ifid_d.valid    = 1'b1;
                            cnt_d           = cnt_q + 32'd1;
                        end
                    endcase
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            ifid_q   <= IFID_BUBBLE;
            halted_q <= 1'b0;
            cause_q  <= HC_NONE;
            cnt_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifid_q   <= ifid_d;
            halted_q <= halted_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.imem_addr      = pc_next[IMEM_AW+1:2];
    assign bus.imem_en        = imem_en;
    assign bus.IF_ID_pc       = ifid_q.pc;
    assign bus.IF_ID_pc_plus4 = ifid_q.pc_plus4;
    assign bus.IF_ID_instr    = ifid_q.instr;
    assign bus.IF_ID_valid    = ifid_q.valid;
    assign bus.halted         = halted_q;
    assign bus.halt_cause     = cause_q;
    assign bus.fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table plus
// a randomized stall/redirect stream checked against an expected-fetch queue.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk;
    logic rst;

    fetch_if #(.IMEM_AW(12)) bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_AW   (12),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [4096];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 32'h1000 + 32'(i);
        end
    end

    always @(posedge clk) begin
        if (bus.imem_en) begin
            bus.imem_rdata <= mem[bus.imem_addr];
        end
    end

    typedef struct {
        logic        st;
        logic        fl;
        logic [1:0]  sel;
        logic [31:0] br;
        logic [31:0] jt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] ecnt;
        logic        eh;
        logic [1:0]  ec;
        logic        een;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t tbl [$];
    exp_t sbq [$];

    int n_cmp;
    int n_fail;

    logic [31:0] fp;
    logic [31:0] ecnt;
    logic        hv;
    logic [31:0] hpc;

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic st, input logic fl, input logic [1:0] sel,
        input logic [31:0] br, input logic [31:0] jt,
        input logic ev, input logic [31:0] epc, input logic [31:0] ei,
        input logic [31:0] ec_nt, input logic eh, input logic [1:0] ec,
        input logic een
    );
        vec_t v;
        v.st = st; v.fl = fl; v.sel = sel; v.br = br; v.jt = jt;
        v.ev = ev; v.epc = epc; v.einstr = ei; v.ecnt = ec_nt;
        v.eh = eh; v.ec = ec; v.een = een;
        return v;
    endfunction

    task automatic drive(input logic st, input logic fl, input logic [1:0] sel,
                         input logic [31:0] br, input logic [31:0] jt);
        bus.stall         = st;
        bus.flush         = fl;
        bus.pc_sel        = sel;
        bus.branch_target = br;
        bus.jump_target   = jt;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(bus.IF_ID_valid), 32'd0);
        check({tag, "_pc"}, bus.IF_ID_pc, 32'd0);
        check({tag, "_pc4"}, bus.IF_ID_pc_plus4, 32'd4);
        check({tag, "_instr"}, bus.IF_ID_instr, NOP);
        check({tag, "_cnt"}, bus.fetch_count, 32'd0);
        check({tag, "_halted"}, 32'(bus.halted), 32'd0);
        check({tag, "_cause"}, 32'(bus.halt_cause), 32'd0);
    endtask

    // Caller must have completed the BOOT edge with IF/ID a bubble.
    task automatic run_sb(input int n);
        logic        st;
        logic        fl;
        logic [31:0] tgt;
        exp_t        e;
        hv  = 1'b0;
        hpc = 32'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 11) == 0);
            tgt = 32'($urandom_range(0, 3071)) << 2;
            if (fl) begin
                drive(st, 1'b1, ($urandom_range(0, 1) == 0) ? PC_BRANCH : PC_JUMP,
                      tgt, tgt);
                fp = tgt;
            end else begin
                drive(st, 1'b0, PC_SEQ, 32'd0, 32'd0);
                if (!st) begin
                    sbq.push_back('{pc: fp, instr: 32'h1000 + {20'd0, fp[13:2]}});
                    fp   = fp + 32'd4;
                    ecnt = ecnt + 32'd1;
                end
            end
            @(posedge clk);
            #1;
            if (fl) begin
                check("sb_flush_valid", 32'(bus.IF_ID_valid), 32'd0);
                check("sb_flush_instr", bus.IF_ID_instr, NOP);
                hv  = 1'b0;
                hpc = 32'd0;
            end else if (st) begin
                check("sb_stall_valid", 32'(bus.IF_ID_valid), 32'(hv));
                check("sb_stall_pc", bus.IF_ID_pc, hpc);
            end else begin
                e = sbq.pop_front();
                check("sb_valid", 32'(bus.IF_ID_valid), 32'd1);
                check("sb_pc", bus.IF_ID_pc, e.pc);
                check("sb_pc4", bus.IF_ID_pc_plus4, e.pc + 32'd4);
                check("sb_instr", bus.IF_ID_instr, e.instr);
                hv  = 1'b1;
                hpc = e.pc;
            end
            check("sb_cnt", bus.fetch_count, ecnt);
        end
        drive(1'b0, 1'b0, PC_SEQ, 32'd0, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        tbl.push_back(mk(0,0,2'b00,0,0,        0,32'h00,NOP,         0,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b00,0,0,        1,32'h00,32'h1000,    1,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b00,0,0,        1,32'h04,32'h1001,    2,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b00,0,0,        1,32'h08,32'h1002,    3,0,2'b00,1));
        tbl.push_back(mk(1,0,2'b00,0,0,        1,32'h08,32'h1002,    3,0,2'b00,1));
        tbl.push_back(mk(1,0,2'b00,0,0,        1,32'h08,32'h1002,    3,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b00,0,0,        1,32'h0C,32'h1003,    4,0,2'b00,1));
        tbl.push_back(mk(0,1,2'b01,32'h40,0,   0,32'h00,NOP,         4,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b00,0,0,        1,32'h40,32'h1010,    5,0,2'b00,1));
        tbl.push_back(mk(1,1,2'b10,0,32'h80,   0,32'h00,NOP,         5,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b00,0,0,        1,32'h80,32'h1020,    6,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b11,0,0,        1,32'h84,32'h1021,    7,0,2'b00,1));
        tbl.push_back(mk(0,0,2'b10,0,32'h42,   0,32'h00,NOP,         7,1,2'b01,0));
        tbl.push_back(mk(0,0,2'b01,32'h100,0,  0,32'h00,NOP,         7,1,2'b01,0));

        rst = 1'b1;
        drive(1'b0, 1'b0, PC_SEQ, 32'd0, 32'd0);
        #2;
        check_reset_vals("rst0");

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("boot_addr", 32'(bus.imem_addr), 32'd0);
        check("boot_en", 32'(bus.imem_en), 32'd1);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].sel, tbl[i].br, tbl[i].jt);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(bus.IF_ID_valid), 32'(tbl[i].ev));
            check($sformatf("v%0d_pc", i), bus.IF_ID_pc, tbl[i].epc);
            check($sformatf("v%0d_instr", i), bus.IF_ID_instr, tbl[i].einstr);
            check($sformatf("v%0d_cnt", i), bus.fetch_count, tbl[i].ecnt);
            check($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(tbl[i].eh));
            check($sformatf("v%0d_cause", i), 32'(bus.halt_cause), 32'(tbl[i].ec));
            check($sformatf("v%0d_en", i), 32'(bus.imem_en), 32'(tbl[i].een));
            @(negedge clk);
        end

        // Region violation after a fresh restart.
        drive(1'b0, 1'b0, PC_SEQ, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        check_reset_vals("rst1");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("r1_boot_valid", 32'(bus.IF_ID_valid), 32'd0);
        @(posedge clk);
        #1;
        check("r1_first_pc", bus.IF_ID_pc, 32'd0);
        check("r1_first_instr", bus.IF_ID_instr, 32'h1000);
        @(negedge clk);
        drive(1'b0, 1'b0, PC_BRANCH, 32'h2000_0000, 32'd0);
        @(posedge clk);
        #1;
        check("r1_halted", 32'(bus.halted), 32'd1);
        check("r1_cause", 32'(bus.halt_cause), 32'(2'b10));
        check("r1_en", 32'(bus.imem_en), 32'd0);
        check("r1_valid", 32'(bus.IF_ID_valid), 32'd0);
        check("r1_cnt", bus.fetch_count, 32'd1);

        // Restart and run a random stream.
        @(negedge clk);
        drive(1'b0, 1'b0, PC_SEQ, 32'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("r2_boot_valid", 32'(bus.IF_ID_valid), 32'd0);
        fp   = 32'd0;
        ecnt = 32'd0;
        run_sb(150);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
        check("arst_en", 32'(bus.imem_en), 32'd1);
        check("arst_addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("r3_boot_valid", 32'(bus.IF_ID_valid), 32'd0);
        sbq.delete();
        fp   = 32'd0;
        ecnt = 32'd0;
        run_sb(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
